eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet transmit pipeline (dibit-in `tether` framer feeding RMII eth_txen/eth_txd) between NUM_SRC packet sources.
- Round-robin grant, one frame at a time.
- Enforces an inter-frame gap that covers framer drain plus the Ethernet IFG.
- Guards the framer against runaway sources with a start timeout and a maximum-length truncation.

Parameters:
- NUM_SRC, 2, number of requesting sources (2..8).
- GAP_CYCLES, 64, idle clk cycles after a frame's last forwarded dibit before the next grant (covers CRC append plus 48-dibit IFG).
- MAX_DIBITS, 6000, maximum dibits forwarded per frame (1500 bytes).
- START_TIMEOUT, 16, cycles a granted source has to raise valid.

Ports:
- clk  input  1  system clock (50 MHz RMII domain).
- rst  input  1  asynchronous, active-low reset; 0 resets.
- req  input  NUM_SRC  per-source frame request, level.
- gnt  output  NUM_SRC  one-hot grant, registered.
- src_axiiv  input  NUM_SRC  per-source dibit valid.
- src_axiid  input  2*NUM_SRC  per-source dibit; source i on bits [2i+1:2i].
- axiov  output  1  dibit valid to framer axiiv.
- axiod  output  2  dibit to framer axiid.
- busy  output  1  high in any state except IDLE.
- overrun  output  1  one-cycle pulse on MAX_DIBITS truncation.
- timeout  output  1  one-cycle pulse on start timeout.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gnt=0, axiov=0, axiod=0, busy=0, overrun=0, timeout=0, rr pointer=NUM_SRC-1 (so source 0 wins first), counters=0.
- IDLE:
  - If req!=0, select the first set req bit searching upward from rr+1 with wrap.
  - Next edge: gnt=onehot(sel), rr=sel, state=GRANT.
- GRANT:
  - src_axiiv[sel]=1 -> STREAM, forwarding that dibit.
  - req[sel]=0 before valid -> gnt=0, IDLE (no gap).
  - Wait counter reaches START_TIMEOUT -> gnt=0, timeout pulse, IDLE.
- STREAM:
  - Each cycle, axiov<=src_axiiv[sel] and axiod<=src_axiid[sel]: exactly 1 cycle latency, registered.
  - Dibit count increments per forwarded dibit.
  - First cycle src_axiiv[sel]=0 ends the frame: axiov<=0, axiod<=0, gnt<=0, state=GAP with gap counter cleared.
- Truncation: when the count reaches MAX_DIBITS and src_axiiv[sel] is still 1:
  - That dibit is not forwarded: axiov<=0, overrun pulses, gnt<=0, state=DRAIN.
- DRAIN: axiov=0; wait for src_axiiv[sel]=0, then GAP.
- GAP: axiov=0; counter counts GAP_CYCLES cycles, then IDLE. New requests are held off, not lost (req is level).
- Non-selected sources' src_axiiv/src_axiid are ignored at all times; their valid never reaches axiov.
- A granted source must not raise valid before it sees gnt. Valid seen in the same cycle gnt rises is accepted.
- A frame must be contiguous: a valid gap terminates it, and a later valid is ignored until a new grant.
- gnt is never asserted in GAP/DRAIN/IDLE, and is never multi-hot.
- Reset asserted mid-frame: outputs drop to 0 asynchronously. The framer sees a truncated frame; this is accepted behaviour.
- Counter widths: $clog2(MAX_DIBITS+1), $clog2(GAP_CYCLES+1), $clog2(START_TIMEOUT+1).

Test Plan:
- Single source, NUM_SRC=2: req[0]=1, 4 dibits 01,10,10,01.
  - gnt=01 one cycle after req.
  - axiov high exactly 4 cycles, axiod 01,10,10,01, each 1 cycle after input.
  - gnt drops the cycle after valid falls; busy stays high a further GAP_CYCLES cycles.
- Both req raised the same cycle after reset, 8 dibits each.
  - Source 0 is served first.
  - gnt=10 is asserted exactly GAP_CYCLES+1 cycles after source 0's last axiov.
  - No axiov activity in between.
- Fairness: req[0] and req[1] held high for 4 frames -> grant order 0,1,0,1.
- Overrun, MAX_DIBITS=8: source streams 12 dibits of 01.
  - axiov high exactly 8 cycles, then overrun pulses once.
  - gnt drops; GAP starts only after source valid falls.
- Start timeout: req[1]=1, valid never raised.
  - gnt=10 for START_TIMEOUT cycles, then gnt=0 with timeout pulse.
  - Next req[0] is granted without a gap.
- Reset mid-stream: rst=0 during dibit 3 of 22 bytes.
  - axiov, gnt, busy are 0 within the same cycle.
  - After release with req[0] high, source 0 is granted normally.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin arbiter sharing one RMII dibit framer between NUM_SRC sources
// Enforces inter-frame gap, start timeout and maximum-length truncation.
module eth_tx_arbiter #(
   parameter int NUM_SRC       = 2,
   parameter int GAP_CYCLES    = 64,
   parameter int MAX_DIBITS    = 6000,
   parameter int START_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SRC-1:0]   req,
   output logic [NUM_SRC-1:0]   gnt,
   input  logic [NUM_SRC-1:0]   src_axiiv,
   input  logic [2*NUM_SRC-1:0] src_axiid,
   output logic                 axiov,
   output logic [1:0]           axiod,
   output logic                 busy,
   output logic                 overrun,
   output logic                 timeout
);

   localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int DCNT_W = $clog2(MAX_DIBITS + 1);
   localparam int GCNT_W = $clog2(GAP_CYCLES + 1);
   localparam int WCNT_W = $clog2(START_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_STREAM,
      S_DRAIN,
      S_GAP
   } state_t;

   state_t              state, state_n;
   logic [SEL_W-1:0]    sel, sel_n;
   logic [SEL_W-1:0]    rr, rr_n;
   logic [NUM_SRC-1:0]  gnt_n;
   logic                axiov_n;
   logic [1:0]          axiod_n;
   logic                overrun_n;
   logic                timeout_n;
   logic [DCNT_W-1:0]   dcnt, dcnt_n;
   logic [GCNT_W-1:0]   gcnt, gcnt_n;
   logic [WCNT_W-1:0]   wcnt, wcnt_n;

   logic                arb_found;
   logic [SEL_W-1:0]    arb_sel;
   logic [NUM_SRC-1:0]  arb_onehot;
   logic [SEL_W:0]      cand;
   logic                cur_v;
   logic                cur_req;
   logic [1:0]          cur_d;

   // Round-robin search upward from rr+1, wrapping at NUM_SRC.
   always_comb begin
      arb_found  = 1'b0;
      arb_sel    = '0;
      arb_onehot = '0;
      cand       = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = {1'b0, rr} + (SEL_W+1)'(k);
         if (cand >= (SEL_W+1)'(NUM_SRC))
            cand = cand - (SEL_W+1)'(NUM_SRC);
         if (!arb_found && req[cand[SEL_W-1:0]]) begin
            arb_found = 1'b1;
            arb_sel   = cand[SEL_W-1:0];
         end
      end
      for (int i = 0; i < NUM_SRC; i++)
         if (SEL_W'(i) == arb_sel)
            arb_onehot[i] = 1'b1;
   end

   always_comb begin
      cur_v   = 1'b0;
      cur_req = 1'b0;
      cur_d   = 2'b00;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (SEL_W'(i) == sel) begin
            cur_v   = src_axiiv[i];
            cur_req = req[i];
            cur_d   = src_axiid[2*i +: 2];
         end
      end
   end

   always_comb begin
      state_n   = state;
      sel_n     = sel;
      rr_n      = rr;
      gnt_n     = gnt;
      axiov_n   = 1'b0;
      axiod_n   = 2'b00;
      overrun_n = 1'b0;
      timeout_n = 1'b0;
      dcnt_n    = dcnt;
      gcnt_n    = gcnt;
      wcnt_n    = wcnt;
      case (state)
         S_IDLE: begin
            if (arb_found) begin
               state_n = S_GRANT;
               sel_n   = arb_sel;
               rr_n    = arb_sel;
               gnt_n   = arb_onehot;
               wcnt_n  = '0;
            end
         end
         S_GRANT: begin
            if (cur_v) begin
               state_n = S_STREAM;
               axiov_n = 1'b1;
               axiod_n = cur_d;
               dcnt_n  = DCNT_W'(1);
            end else if (!cur_req) begin
               state_n = S_IDLE;
               gnt_n   = '0;
            end else if (wcnt == WCNT_W'(START_TIMEOUT - 1)) begin
               state_n   = S_IDLE;
               gnt_n     = '0;
               timeout_n = 1'b1;
            end else begin
               wcnt_n = wcnt + 1'b1;
            end
         end
         S_STREAM: begin
            if (!cur_v) begin
               state_n = S_GAP;
               gnt_n   = '0;
               gcnt_n  = '0;
            end else if (dcnt == DCNT_W'(MAX_DIBITS)) begin
               state_n   = S_DRAIN;
               gnt_n     = '0;
               overrun_n = 1'b1;
            end else begin
               axiov_n = 1'b1;
               axiod_n = cur_d;
               dcnt_n  = dcnt + 1'b1;
            end
         end
         S_DRAIN: begin
            if (!cur_v) begin
               state_n = S_GAP;
               gcnt_n  = '0;
            end
         end
         S_GAP: begin
            // The last gap cycle arbitrates directly so the grant lands GAP_CYCLES+1 after the last dibit.
            if (gcnt == GCNT_W'(GAP_CYCLES - 1)) begin
               if (arb_found) begin
                  state_n = S_GRANT;
                  sel_n   = arb_sel;
                  rr_n    = arb_sel;
                  gnt_n   = arb_onehot;
                  wcnt_n  = '0;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               gcnt_n = gcnt + 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         sel     <= '0;
         rr      <= SEL_W'(NUM_SRC - 1);
         gnt     <= '0;
         axiov   <= 1'b0;
         axiod   <= 2'b00;
         overrun <= 1'b0;
         timeout <= 1'b0;
         dcnt    <= '0;
         gcnt    <= '0;
         wcnt    <= '0;
      end else begin
         state   <= state_n;
         sel     <= sel_n;
         rr      <= rr_n;
         gnt     <= gnt_n;
         axiov   <= axiov_n;
         axiod   <= axiod_n;
         overrun <= overrun_n;
         timeout <= timeout_n;
         dcnt    <= dcnt_n;
         gcnt    <= gcnt_n;
         wcnt    <= wcnt_n;
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - scoreboard bench for eth_tx_arbiter
// Inputs and observations happen on the falling edge.
module tb_eth_tx_arbiter;

   localparam int NUM_SRC       = 2;
   localparam int GAP_CYCLES    = 64;
   localparam int MAX_DIBITS    = 8;
   localparam int START_TIMEOUT = 16;

   logic                 clk;
   logic                 rst;
   logic [NUM_SRC-1:0]   req;
   logic [NUM_SRC-1:0]   gnt;
   logic [NUM_SRC-1:0]   src_axiiv;
   logic [2*NUM_SRC-1:0] src_axiid;
   logic                 axiov;
   logic [1:0]           axiod;
   logic                 busy;
   logic                 overrun;
   logic                 timeout;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int axiov_cnt = 0;
   int overrun_cnt = 0;
   int timeout_cnt = 0;
   int last_axiov_cyc = 0;
   logic [1:0] exp_q [$];
   logic [1:0] frame_d [$];
   logic [1:0] exp_d;

   eth_tx_arbiter #(
      .NUM_SRC(NUM_SRC),
      .GAP_CYCLES(GAP_CYCLES),
      .MAX_DIBITS(MAX_DIBITS),
      .START_TIMEOUT(START_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .gnt(gnt),
      .src_axiiv(src_axiiv),
      .src_axiid(src_axiid),
      .axiov(axiov),
      .axiod(axiod),
      .busy(busy),
      .overrun(overrun),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   always @(negedge clk) begin
      if (axiov === 1'b1) begin
         axiov_cnt++;
         last_axiov_cyc = cyc;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_axiov: axiod=%b seen, required no output", axiod);
         end else begin
            exp_d = exp_q.pop_front();
            if (axiod !== exp_d) begin
               n_err++;
               $display("FAIL axiod_data: got %b, required %b", axiod, exp_d);
            end
         end
      end
      if (overrun === 1'b1) begin
         overrun_cnt++;
         n_cmp++;
         if (gnt !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_state: gnt=%b busy=%b, required gnt=00 busy=1", gnt, busy);
         end
      end
      if (timeout === 1'b1) timeout_cnt++;
      if (gnt !== '0) begin
         n_cmp++;
         if ($countones(gnt) != 1) begin
            n_err++;
            $display("FAIL gnt_onehot: gnt=%b, required one-hot", gnt);
         end
      end
   end

   task automatic fill_random(input int n);
      frame_d.delete();
      for (int i = 0; i < n; i++) frame_d.push_back(2'($urandom_range(0, 3)));
   endtask

   // Source s waits for its grant, then streams frame_d contiguously.
   task automatic run_frame(input int s, input bit drop_req);
      int w = 0;
      while (gnt[s] !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (gnt[s] !== 1'b1) begin
         n_err++;
         $display("FAIL grant_wait: src %0d gnt=%b, required bit %0d set", s, gnt, s);
      end
      for (int i = 0; i < frame_d.size(); i++) begin
         if (i == 1) begin
            n_cmp++;
            if (axiov !== 1'b1) begin
               n_err++;
               $display("FAIL first_latency: axiov=%b one cycle after first dibit, required 1", axiov);
            end
         end
         src_axiiv[s]       = 1'b1;
         src_axiid[2*s +: 2] = frame_d[i];
         if (i < MAX_DIBITS) exp_q.push_back(frame_d[i]);
         @(negedge clk);
      end
      src_axiiv[s]       = 1'b0;
      src_axiid[2*s +: 2] = 2'b00;
      if (drop_req) req[s] = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int w = 0;
      while (busy !== 1'b0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL wait_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (gnt !== 2'b00 || axiov !== 1'b0 || axiod !== 2'b00 || busy !== 1'b0 ||
          overrun !== 1'b0 || timeout !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: gnt=%b axiov=%b axiod=%b busy=%b ovr=%b to=%b, required all 0",
                  gnt, axiov, axiod, busy, overrun, timeout);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || gnt !== 2'b00) begin
         n_err++;
         $display("FAIL reset_release: busy=%b gnt=%b, required 0/00", busy, gnt);
      end
   endtask

   task automatic test_single();
      int bc = 0;
      src_axiiv[1]   = 1'b1;
      src_axiid[3:2] = 2'b11;
      req[0]         = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (gnt !== 2'b01) begin
         n_err++;
         $display("FAIL single_gnt: gnt=%b one cycle after req, required 01", gnt);
      end
      axiov_cnt = 0;
      frame_d = '{2'b01, 2'b10, 2'b10, 2'b01};
      run_frame(0, 1'b1);
      n_cmp++;
      if (gnt !== 2'b00 || axiov !== 1'b0) begin
         n_err++;
         $display("FAIL single_end: gnt=%b axiov=%b after valid fell, required 00/0", gnt, axiov);
      end
      n_cmp++;
      if (axiov_cnt != 4) begin
         n_err++;
         $display("FAIL single_len: axiov high %0d cycles, required 4", axiov_cnt);
      end
      while (busy === 1'b1 && bc < 200) begin
         bc++;
         @(negedge clk);
      end
      n_cmp++;
      if (bc != GAP_CYCLES) begin
         n_err++;
         $display("FAIL single_gap: busy high %0d cycles after gnt drop, required %0d", bc, GAP_CYCLES);
      end
      src_axiiv[1]   = 1'b0;
      src_axiid[3:2] = 2'b00;
   endtask

   task automatic test_both();
      int cnt0;
      int w = 0;
      req = 2'b11;
      @(negedge clk);
      n_cmp++;
      if (gnt !== 2'b01) begin
         n_err++;
         $display("FAIL both_first: gnt=%b, required 01", gnt);
      end
      fill_random(8);
      run_frame(0, 1'b1);
      cnt0 = axiov_cnt;
      while (gnt !== 2'b10 && w < 200) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (cyc - last_axiov_cyc != GAP_CYCLES + 1) begin
         n_err++;
         $display("FAIL both_gap: second grant %0d cycles after last axiov, required %0d",
                  cyc - last_axiov_cyc, GAP_CYCLES + 1);
      end
      n_cmp++;
      if (axiov_cnt != cnt0) begin
         n_err++;
         $display("FAIL both_quiet: %0d axiov cycles during gap, required 0", axiov_cnt - cnt0);
      end
      fill_random(8);
      run_frame(1, 1'b1);
      wait_idle();
   endtask

   task automatic test_fairness();
      int s;
      req = 2'b11;
      for (int f = 0; f < 4; f++) begin
         int w = 0;
         while (gnt === 2'b00 && w < 200) begin
            @(negedge clk);
            w++;
         end
         n_cmp++;
         if (gnt !== 2'(1 << (f % 2))) begin
            n_err++;
            $display("FAIL fair_order: frame %0d gnt=%b, required %b", f, gnt, 2'(1 << (f % 2)));
         end
         s = (gnt[1] === 1'b1) ? 1 : 0;
         fill_random(3);
         run_frame(s, 1'b0);
      end
      req = 2'b00;
      wait_idle();
   endtask

   task automatic test_overrun();
      int bc = 0;
      req[0] = 1'b1;
      @(negedge clk);
      axiov_cnt = 0;
      overrun_cnt = 0;
      frame_d.delete();
      for (int i = 0; i < 12; i++) frame_d.push_back(2'b01);
      run_frame(0, 1'b1);
      n_cmp++;
      if (axiov_cnt != MAX_DIBITS) begin
         n_err++;
         $display("FAIL ovr_len: axiov high %0d cycles, required %0d", axiov_cnt, MAX_DIBITS);
      end
      n_cmp++;
      if (overrun_cnt != 1) begin
         n_err++;
         $display("FAIL ovr_pulse: overrun high %0d cycles, required 1", overrun_cnt);
      end
      while (busy === 1'b1 && bc < 200) begin
         bc++;
         @(negedge clk);
      end
      n_cmp++;
      if (bc != GAP_CYCLES) begin
         n_err++;
         $display("FAIL ovr_gap: busy %0d cycles after valid fell, required %0d", bc, GAP_CYCLES);
      end
   endtask

   task automatic test_timeout();
      int w = 0;
      int gc = 0;
      timeout_cnt = 0;
      req = 2'b10;
      while (gnt !== 2'b10 && w < 50) begin
         @(negedge clk);
         w++;
      end
      while (gnt === 2'b10 && gc < 100) begin
         gc++;
         @(negedge clk);
      end
      n_cmp++;
      if (gc != START_TIMEOUT) begin
         n_err++;
         $display("FAIL to_len: gnt=10 for %0d cycles, required %0d", gc, START_TIMEOUT);
      end
      n_cmp++;
      if (timeout !== 1'b1 || busy !== 1'b0 || gnt !== 2'b00) begin
         n_err++;
         $display("FAIL to_pulse: timeout=%b busy=%b gnt=%b, required 1/0/00", timeout, busy, gnt);
      end
      req = 2'b01;
      @(negedge clk);
      n_cmp++;
      if (gnt !== 2'b01 || timeout !== 1'b0 || timeout_cnt != 1) begin
         n_err++;
         $display("FAIL to_next: gnt=%b timeout=%b pulses=%0d, required 01/0/1", gnt, timeout, timeout_cnt);
      end
      fill_random(2);
      run_frame(0, 1'b1);
      wait_idle();
   endtask

   task automatic test_reset_mid();
      req = 2'b01;
      @(negedge clk);
      fill_random(88);
      for (int i = 0; i < 4; i++) begin
         src_axiiv[0]   = 1'b1;
         src_axiid[1:0] = frame_d[i];
         if (i < 3) begin
            exp_q.push_back(frame_d[i]);
            @(negedge clk);
         end else begin
            n_cmp++;
            if (axiov !== 1'b1) begin
               n_err++;
               $display("FAIL mid_active: axiov=%b before reset, required 1", axiov);
            end
            #2 rst = 1'b0;
            #1;
            n_cmp++;
            if (axiov !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0) begin
               n_err++;
               $display("FAIL mid_async: axiov=%b gnt=%b busy=%b, required 0/00/0", axiov, gnt, busy);
            end
            @(negedge clk);
         end
      end
      src_axiiv[0]   = 1'b0;
      src_axiid[1:0] = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (gnt !== 2'b01) begin
         n_err++;
         $display("FAIL mid_regrant: gnt=%b after release, required 01", gnt);
      end
      fill_random(4);
      run_frame(0, 1'b1);
      wait_idle();
   endtask

   initial begin
      rst       = 1'b0;
      req       = '0;
      src_axiiv = '0;
      src_axiid = '0;
      test_reset();
      test_single();
      apply_reset();
      test_both();
      test_fairness();
      test_overrun();
      test_timeout();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d dibits never seen, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
